// File: rtl/snn_pkg.sv
// Shared SNN definitions: arbiter FSM encoding and default learning/counter sizes.
package snn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_LEARN = 2'd2
   } snn_state_t;

   localparam int SNN_LEARN_CYC = 3;
   localparam int SNN_CNT_W     = 2;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snn_spike_arbiter_if.sv
// Spike event handshake towards the shared synapse unit: valid/ready plus source index.
interface snn_spike_arbiter_if #(
   parameter int SRC_W = 2
) ();
   logic             ev_valid;
   logic             ev_ready;
   logic [SRC_W-1:0] ev_src;

   modport master (output ev_valid, output ev_src, input ev_ready);
   modport slave  (input ev_valid, input ev_src, output ev_ready);
endinterface

// File: rtl/snn_spike_arbiter_rr_pick.sv
// Rotate-priority find-first: first set req bit scanning ptr+1, ptr+2, ... (mod N_SRC).
// Purely combinational, no latency, no backpressure.
module rr_pick #(
   parameter int N_SRC = 4,
   parameter int SRC_W = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SRC_W-1:0] ptr,
   output logic             any,
   output logic [SRC_W-1:0] idx
);

   logic [SRC_W-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest hit wins.
   always_comb begin
      any  = |req;
      idx  = '0;
      cand = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         cand = SRC_W'((int'(ptr) + k) % N_SRC);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/snn_spike_arbiter.sv
// Round-robin arbiter of buffered presynaptic spikes onto one STDP datapath; spike->ev_valid in 2 cycles.
// Event held until ev_ready; issue pauses for the post-spike learning window while counters keep accumulating.
module snn_spike_arbiter
   import snn_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int CNT_W     = SNN_CNT_W,
   parameter int LEARN_CYC = SNN_LEARN_CYC,
   parameter int SRC_W     = $clog2(N_SRC)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [N_SRC-1:0]    spike_in,
   input  logic                post_spike,
   input  logic [N_SRC-1:0]    drop_clr,
   snn_spike_arbiter_if.master ev,
   output logic                learn_busy,
   output logic                pend_any,
   output logic [N_SRC-1:0]    drop_flags
);

   localparam int              LW       = width_of(LEARN_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LW-1:0]   LRN_LOAD = LW'(LEARN_CYC - 1);

   logic [CNT_W-1:0] cnt     [N_SRC];
   logic [CNT_W-1:0] cnt_nxt [N_SRC];
   logic [N_SRC-1:0] nz;
   logic [N_SRC-1:0] dec;
   logic [N_SRC-1:0] drop_set;
   logic             pend_nxt;
   logic             hs;

   snn_state_t       state, state_nxt;
   logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [SRC_W-1:0] src_nxt, pick_idx;
   logic             pick_any;
   logic             valid_nxt;
   logic             learn_req, learn_req_nxt;
   logic [LW-1:0]    learn_cnt, learn_cnt_nxt;

   assign hs = ev.ev_valid & ev.ev_ready;

   always_comb begin
      drop_set = '0;
      nz       = '0;
      dec      = '0;
      pend_nxt = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         cnt_nxt[i] = cnt[i];
         nz[i]      = (cnt[i] != '0);
         dec[i]     = hs && (ev.ev_src == SRC_W'(i));
         if (spike_in[i] && !dec[i]) begin
            if (cnt[i] == CNT_MAX) drop_set[i] = 1'b1;
            else                   cnt_nxt[i]  = cnt[i] + CNT_W'(1);
         end else if (!spike_in[i] && dec[i]) begin
            cnt_nxt[i] = cnt[i] - CNT_W'(1);
         end
         pend_nxt = pend_nxt | (cnt_nxt[i] != '0);
      end
   end

   rr_pick #(
      .N_SRC (N_SRC),
      .SRC_W (SRC_W)
   ) u_rr_pick (
      .req (nz),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_nxt     = state;
      valid_nxt     = ev.ev_valid;
      src_nxt       = ev.ev_src;
      rr_ptr_nxt    = rr_ptr;
      learn_req_nxt = learn_req;
      learn_cnt_nxt = learn_cnt;
      case (state)
         ST_IDLE: begin
            if (post_spike || learn_req) begin
               state_nxt     = ST_LEARN;
               learn_cnt_nxt = LRN_LOAD;
               learn_req_nxt = 1'b0;
            end else if (ena && pick_any) begin
               state_nxt = ST_ISSUE;
               valid_nxt = 1'b1;
               src_nxt   = pick_idx;
            end
         end
         ST_ISSUE: begin
            if (hs) begin
               valid_nxt  = 1'b0;
               rr_ptr_nxt = ev.ev_src;
               if (learn_req || post_spike) begin
                  state_nxt     = ST_LEARN;
                  learn_cnt_nxt = LRN_LOAD;
                  learn_req_nxt = 1'b0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (post_spike) begin
               // Defer learning until the in-flight event has been accepted.
               learn_req_nxt = 1'b1;
            end
         end
         ST_LEARN: begin
            valid_nxt = 1'b0;
            if (post_spike)              learn_cnt_nxt = LRN_LOAD;
            else if (learn_cnt == '0)    state_nxt     = ST_IDLE;
            else                         learn_cnt_nxt = learn_cnt - LW'(1);
         end
         default: begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ev.ev_valid <= 1'b0;
         ev.ev_src   <= '0;
         rr_ptr      <= SRC_W'(N_SRC - 1);
         learn_req   <= 1'b0;
         learn_cnt   <= '0;
         learn_busy  <= 1'b0;
         pend_any    <= 1'b0;
         drop_flags  <= '0;
         for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
      end else begin
         state       <= state_nxt;
         ev.ev_valid <= valid_nxt;
         ev.ev_src   <= src_nxt;
         rr_ptr      <= rr_ptr_nxt;
         learn_req   <= learn_req_nxt;
         learn_cnt   <= learn_cnt_nxt;
         learn_busy  <= (state_nxt == ST_LEARN);
         pend_any    <= pend_nxt;
         drop_flags  <= (drop_flags & ~drop_clr) | drop_set;
         for (int i = 0; i < N_SRC; i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_snn_spike_arbiter.sv
// Directed bench for snn_spike_arbiter: expected event sources are queued by the stimulus and
// popped by a handshake monitor; flag and window outputs are checked directly after each edge.
module tb_snn_spike_arbiter;

   localparam int N_SRC = 4;
   localparam int SRC_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic [N_SRC-1:0] spike_in;
   logic             post_spike;
   logic [N_SRC-1:0] drop_clr;
   logic             learn_busy;
   logic             pend_any;
   logic [N_SRC-1:0] drop_flags;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   snn_spike_arbiter_if #(.SRC_W(SRC_W)) ev_if ();

   snn_spike_arbiter #(
      .N_SRC     (N_SRC),
      .CNT_W     (2),
      .LEARN_CYC (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .spike_in   (spike_in),
      .post_spike (post_spike),
      .drop_clr   (drop_clr),
      .ev         (ev_if),
      .learn_busy (learn_busy),
      .pend_any   (pend_any),
      .drop_flags (drop_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outputs settle 1 time unit after the edge; new inputs then apply at the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      logic done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         step();
         if (!ev_if.ev_valid && !learn_busy && !pend_any) done = 1'b1;
      end
      chk(name, done, 1);
   endtask

   // Handshake monitor: sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (rst_n && ev_if.ev_valid && ev_if.ev_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got src=%0d expected no event", ev_if.ev_src);
         end else begin
            automatic int e = exp_q.pop_front();
            if (int'(ev_if.ev_src) != e) begin
               errors++;
               $display("FAIL event_src: got %0d expected %0d", ev_if.ev_src, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic exp_v2 [6];
      int   exp_s2 [6];
      logic exp_lb4 [6];
      logic exp_v4  [6];
      logic post5   [8];
      logic exp_lb5 [8];

      exp_v2  = '{1, 0, 1, 0, 1, 0};
      exp_s2  = '{0, 0, 1, 1, 3, 3};
      exp_lb4 = '{1, 1, 1, 0, 0, 0};
      exp_v4  = '{0, 0, 0, 0, 1, 0};
      post5   = '{1, 1, 0, 1, 0, 0, 0, 0};
      exp_lb5 = '{1, 1, 1, 1, 1, 1, 0, 0};

      rst_n = 1'b0; ena = 1'b1; spike_in = '0; post_spike = 1'b0;
      drop_clr = '0; ev_if.ev_ready = 1'b0;
      step(); step();
      chk("rst_ev_valid", ev_if.ev_valid, 0);
      chk("rst_ev_src", ev_if.ev_src, 0);
      chk("rst_learn_busy", learn_busy, 0);
      chk("rst_pend_any", pend_any, 0);
      chk("rst_drop_flags", drop_flags, 0);
      rst_n = 1'b1;
      step();

      // Simultaneous spikes on 0,1,3 from reset pointer: order 0, 1, 3, two cycles apart.
      ev_if.ev_ready = 1'b1;
      spike_in = 4'b1011;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      step();
      spike_in = '0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("rr_valid_%0d", k), ev_if.ev_valid, exp_v2[k]);
         if (exp_v2[k]) chk($sformatf("rr_src_%0d", k), ev_if.ev_src, exp_s2[k]);
      end
      chk("rr_pend_empty", pend_any, 0);
      step(); step();
      chk("rr_no_reissue", ev_if.ev_valid, 0);

      // Single spike on source 2.
      spike_in = 4'b0100;
      exp_q.push_back(2);
      step();
      spike_in = '0;
      chk("s1_pend_after_spike", pend_any, 1);
      chk("s1_valid_edge0", ev_if.ev_valid, 0);
      step();
      chk("s1_valid_edge1", ev_if.ev_valid, 1);
      chk("s1_src_edge1", ev_if.ev_src, 2);
      step();
      chk("s1_valid_after_hs", ev_if.ev_valid, 0);
      chk("s1_pend_after_hs", pend_any, 0);

      // Saturation: four spikes on source 1 while the datapath stalls.
      ev_if.ev_ready = 1'b0;
      spike_in = 4'b0010;
      step(); step(); step(); step();
      spike_in = '0;
      chk("sat_drop_set", drop_flags, 4'b0010);
      chk("sat_valid_held", ev_if.ev_valid, 1);
      chk("sat_src", ev_if.ev_src, 1);
      drop_clr = 4'b0010;
      step();
      drop_clr = '0;
      chk("sat_drop_clr", drop_flags, 0);
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
      ev_if.ev_ready = 1'b1;
      wait_idle("sat_drain_idle", 40);
      chk("sat_drop_stays_clear", drop_flags, 0);

      // post_spike during a stalled issue: event held, then learning window, then next issue.
      ev_if.ev_ready = 1'b0;
      spike_in = 4'b1001;
      step();
      spike_in = '0;
      step();
      chk("lrq_valid", ev_if.ev_valid, 1);
      chk("lrq_src", ev_if.ev_src, 3);
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      chk("lrq_src_stable_a", ev_if.ev_src, 3);
      step();
      chk("lrq_valid_stable", ev_if.ev_valid, 1);
      chk("lrq_src_stable_b", ev_if.ev_src, 3);
      exp_q.push_back(3); exp_q.push_back(0);
      ev_if.ev_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("lrq_busy_%0d", k), learn_busy, exp_lb4[k]);
         chk($sformatf("lrq_valid_%0d", k), ev_if.ev_valid, exp_v4[k]);
      end
      chk("lrq_next_src_done", pend_any, 0);

      // Window extension by post_spike inside LEARN.
      for (int k = 0; k < 8; k++) begin
         post_spike = post5[k];
         step();
         chk($sformatf("ext_busy_%0d", k), learn_busy, exp_lb5[k]);
      end
      post_spike = 1'b0;

      // Issue gated by ena, then reset in the middle of an ISSUE.
      ena = 1'b0;
      ev_if.ev_ready = 1'b0;
      spike_in = 4'b0100;
      step(); step();
      spike_in = '0;
      step();
      chk("ena_off_valid", ev_if.ev_valid, 0);
      chk("ena_off_pend", pend_any, 1);
      ena = 1'b1;
      exp_q.push_back(2);
      step();
      chk("ena_on_valid", ev_if.ev_valid, 1);
      chk("ena_on_src", ev_if.ev_src, 2);
      ev_if.ev_ready = 1'b1;
      step();
      chk("ena_hs_valid", ev_if.ev_valid, 0);
      ev_if.ev_ready = 1'b0;
      step();
      chk("ena_second_valid", ev_if.ev_valid, 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_valid", ev_if.ev_valid, 0);
      chk("mid_rst_src", ev_if.ev_src, 0);
      chk("mid_rst_busy", learn_busy, 0);
      chk("mid_rst_pend", pend_any, 0);
      chk("mid_rst_drop", drop_flags, 0);
      rst_n = 1'b1;
      ev_if.ev_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("post_rst_valid_%0d", k), ev_if.ev_valid, 0);
      end
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snn_spike_arbiter.md
Name: snn_spike_arbiter

Overview:
- Shares one synapse/STDP update datapath among N_SRC presynaptic spike sources.
- Buffers each source's spikes in a saturating pending counter and issues events one at a time, round-robin, over a valid/ready handshake.
- Blocks issue during a post-spike learning window, so the shared STDP weight update completes before the next presynaptic event.
- Sits between the neuron array's spike outputs and the shared synapse unit.

Parameters:
- N_SRC, 4, number of spike sources (>=2).
- CNT_W, 2, pending-counter width per source; max pending = 2^CNT_W-1.
- LEARN_CYC, 3, length in cycles of the learning window after post_spike (>=1).
- SRC_W, $clog2(N_SRC), derived width of the source index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  issue enable; low = no new issue, counters still accumulate.
- spike_in  in  N_SRC  per-source spike pulses, one event per high cycle.
- post_spike  in  1  postsynaptic spike; opens the learning window.
- ev_ready  in  1  shared datapath accepts the event.
- drop_clr  in  N_SRC  write-1-to-clear for drop_flags.
- ev_valid  out  1  event offered.
- ev_src  out  SRC_W  index of the offered source.
- learn_busy  out  1  high while in LEARN.
- pend_any  out  1  OR of all pending counters being nonzero (registered).
- drop_flags  out  N_SRC  sticky overflow flag per source.

Behaviour:
- Reset (rst_n low at a clk edge):
  - counters=0, drop_flags=0, ev_valid=0, ev_src=0, learn_busy=0, pend_any=0.
  - rr_ptr=N_SRC-1, learn_req=0, state=IDLE.
- Reset mid-handshake aborts the event silently; the pending event is lost.
- Pending counter i, per edge:
  - +1 if spike_in[i].
  - -1 if handshake (ev_valid & ev_ready) with ev_src==i.
  - Both in the same cycle: unchanged.
  - Increment at max without decrement: stays at max and sets drop_flags[i].
  - drop_clr[i] clears drop_flags[i]. A simultaneous set wins over the clear.
- FSM states: IDLE, ISSUE, LEARN.
- IDLE:
  - If post_spike or learn_req: go to LEARN, learn_cnt=LEARN_CYC-1, clear learn_req.
  - Else if ena and any counter is nonzero: pick the first nonzero source scanning rr_ptr+1, rr_ptr+2, ... (mod N_SRC). Register ev_src, set ev_valid=1, go to ISSUE.
  - Arbitration uses counter values before this edge's updates.
- ISSUE:
  - ev_valid and ev_src are held stable until ev_ready. ena low does not withdraw the event.
  - post_spike while in ISSUE sets learn_req.
  - On handshake: ev_valid=0, rr_ptr=ev_src, decrement the counter. Next state is LEARN if learn_req or post_spike (clear learn_req, learn_cnt=LEARN_CYC-1), else IDLE.
- LEARN:
  - learn_busy=1, ev_valid=0.
  - learn_cnt decrements each cycle; when it reaches 0, go to IDLE.
  - post_spike during LEARN reloads learn_cnt=LEARN_CYC-1 (window extends).
- Latency and throughput:
  - A spike on spike_in at edge k makes the counter nonzero after edge k.
  - ev_valid rises after edge k+1.
  - Throughput is at most one event per 2 cycles (ISSUE, then IDLE).
- Outputs learn_busy and pend_any are registered, computed from next-state values.

Decomposition:
- Shared package snn_pkg: FSM state encoding (IDLE/ISSUE/LEARN) and the default LEARN_CYC and CNT_W constants, for reuse by the STDP and neuron blocks.
- One natural sub-module: rr_pick (combinational rotate-priority find-first over the nonzero-pending vector, given rr_ptr). Counters and FSM stay in the top.

Test Plan:
- Single spike on source 2 at edge 0, ev_ready=1 -> ev_valid=1 with ev_src=2 after edge 1; handshake at edge 2; counter[2]=0; pend_any=0.
- Sources 0,1,3 spike together, ev_ready=1 -> issue order 0, 1, 3 on successive handshakes, 2 cycles apart; then 0 again only if new spikes arrive.
- Four spikes on source 1 with ev_ready=0 (CNT_W=2) -> counter[1]=3, drop_flags[1]=1. drop_clr[1] clears it. Releasing ev_ready yields exactly 3 events.
- ev_valid held, ev_ready=0, post_spike pulsed -> ev_src stable. When ev_ready rises, handshake occurs, then learn_busy=1 for exactly 3 cycles with ev_valid=0, then the next issue.
- post_spike pulses in LEARN at cycles 1 and 3 -> window extends; learn_busy stays high until 3 cycles after the last pulse.
- ena=0 with pending spikes -> ev_valid stays 0 and counters accumulate. ena=1 -> issue resumes. rst_n=0 during ISSUE -> all outputs 0 the next cycle and the event is not issued.
